playfield_board: RTL and testbench

- Owns the locked-cell state of the Tetris playfield: a 10x20 grid of colour codes, where 0 means empty.
- Serves two clients:
  - the active-piece controller, which sends collision-check requests for candidate 4-cell positions and lock requests when a piece lands;
  - the pixel renderer, which reads one cell per cycle addressed by grid column/row.
- After every lock it scans the grid and clears full rows, shifting the rows above down.
- Sits between the piece controller (which consumes can_move) and the colour mapper.

---
 rtl/playfield_board.sv | 179 +++++++++++++++++
 tb/tb_playfield_board.sv | 452 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playfield_board.sv
// rtl/playfield_board.sv - Tetris playfield cell store: collision check, piece lock, line clear, render read
// Optional top-out detection is enabled by defining PLAYFIELD_TOPOUT_EN.
module playfield_board #(
  parameter int COLS     = 10,
  parameter int ROWS     = 20,
  parameter int COLOR_W  = 3,
  parameter int TOP_ROWS = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               check_valid,
  input  logic [19:0]        cand_xblock,
  input  logic [19:0]        cand_yblock,
  output logic               check_done,
  output logic               can_move,
  input  logic               lock_req,
  input  logic [19:0]        lock_xblock,
  input  logic [19:0]        lock_yblock,
  input  logic [COLOR_W-1:0] lock_color,
  output logic               lock_ack,
  output logic               busy,
  output logic               clear_done,
  output logic [2:0]         lines_cleared,
  input  logic               play_area,
  input  logic [4:0]         x_coord,
  input  logic [4:0]         y_coord,
  output logic [COLOR_W-1:0] cell_color,
  output logic               game_over
);

  localparam int XW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int YW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [4:0]    COLS_L   = 5'(COLS);
  localparam logic [4:0]    ROWS_L   = 5'(ROWS);
  localparam logic [YW-1:0] LAST_ROW = YW'(ROWS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Coordinates are 5 bits wide, so the grid cannot exceed 31 in either direction.
  if (ROWS > 31 || COLS > 31 || TOP_ROWS > ROWS) begin : g_bad_geometry
    $error("playfield_board: unsupported geometry");
  end

  logic [ROWS-1:0][COLS-1:0][COLOR_W-1:0] grid;
  logic [1:0]      state;
  logic [YW-1:0]   scan_row;
  logic [2:0]      line_cnt;
  logic [ROWS-1:0] full_rows;
  logic            cand_ok;
  logic            move_ok;
  logic            lock_en;
  logic [4:0]      cx, cy;
  logic [4:0]      lock_x [4];
  logic [4:0]      lock_y [4];
  logic [3:0]      lock_in;

  assign busy = (state != ST_IDLE);

  always_comb begin
    full_rows = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (grid[r][c] == '0) full_rows[r] = 1'b0;
      end
    end
  end

  always_comb begin
    cand_ok = 1'b1;
    cx      = '0;
    cy      = '0;
    for (int i = 0; i < 4; i++) begin
      cx = cand_xblock[19-5*i -: 5];
      cy = cand_yblock[19-5*i -: 5];
      if (cx >= COLS_L || cy >= ROWS_L) cand_ok = 1'b0;
      else if (grid[cy[YW-1:0]][cx[XW-1:0]] != '0) cand_ok = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lock_x[i]  = lock_xblock[19-5*i -: 5];
      lock_y[i]  = lock_yblock[19-5*i -: 5];
      lock_in[i] = (lock_x[i] < COLS_L) && (lock_y[i] < ROWS_L);
    end
  end

`ifdef PLAYFIELD_TOPOUT_EN
  logic top_hit;

  always_comb begin
    top_hit = 1'b0;
    for (int r = 0; r < TOP_ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (grid[r][c] != '0) top_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) game_over <= 1'b0;
    else if (state == ST_DONE && top_hit) game_over <= 1'b1;
  end

  assign lock_en = lock_req && !game_over;
  assign move_ok = cand_ok && !game_over;
`else
  assign game_over = 1'b0;
  assign lock_en   = lock_req;
  assign move_ok   = cand_ok;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= ST_IDLE;
      scan_row      <= '0;
      line_cnt      <= '0;
      check_done    <= 1'b0;
      can_move      <= 1'b0;
      lock_ack      <= 1'b0;
      clear_done    <= 1'b0;
      lines_cleared <= '0;
    end else begin
      check_done <= 1'b0;
      lock_ack   <= 1'b0;
      clear_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (lock_en) begin
            lock_ack <= 1'b1;
            scan_row <= LAST_ROW;
            line_cnt <= '0;
            state    <= ST_SCAN;
          end else if (check_valid) begin
            check_done <= 1'b1;
            can_move   <= move_ok;
          end
        end
        ST_SCAN: begin
          // A cleared row pulls new contents into r, so r is rescanned.
          if (full_rows[scan_row]) line_cnt <= line_cnt + 3'd1;
          else if (scan_row == '0) state <= ST_DONE;
          else scan_row <= scan_row - YW'(1);
        end
        ST_DONE: begin
          clear_done    <= 1'b1;
          lines_cleared <= line_cnt;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      grid <= '0;
    end else if (state == ST_IDLE && lock_en) begin
      for (int i = 0; i < 4; i++) begin
        if (lock_in[i]) grid[lock_y[i][YW-1:0]][lock_x[i][XW-1:0]] <= lock_color;
      end
    end else if (state == ST_SCAN && full_rows[scan_row]) begin
      for (int r = 1; r < ROWS; r++) begin
        if (r <= int'(scan_row)) grid[r] <= grid[r-1];
      end
      grid[0] <= '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) cell_color <= '0;
    else if (play_area && x_coord < COLS_L && y_coord < ROWS_L)
      cell_color <= grid[y_coord[YW-1:0]][x_coord[XW-1:0]];
    else cell_color <= '0;
  end

endmodule

// File: tb/tb_playfield_board.sv
// tb/tb_playfield_board.sv - self-checking bench for playfield_board against a row-compaction grid model
module tb_playfield_board;
  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        check_valid;
  logic [19:0] cand_xblock, cand_yblock;
  logic        check_done, can_move;
  logic        lock_req;
  logic [19:0] lock_xblock, lock_yblock;
  logic [2:0]  lock_color;
  logic        lock_ack, busy, clear_done;
  logic [2:0]  lines_cleared;
  logic        play_area;
  logic [4:0]  x_coord, y_coord;
  logic [2:0]  cell_color;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int m [ROWS][COLS];
  bit m_over;

  always #10 Clk = ~Clk;

  playfield_board dut (
    .Clk(Clk), .Reset(Reset),
    .check_valid(check_valid), .cand_xblock(cand_xblock), .cand_yblock(cand_yblock),
    .check_done(check_done), .can_move(can_move),
    .lock_req(lock_req), .lock_xblock(lock_xblock), .lock_yblock(lock_yblock),
    .lock_color(lock_color), .lock_ack(lock_ack), .busy(busy),
    .clear_done(clear_done), .lines_cleared(lines_cleared),
    .play_area(play_area), .x_coord(x_coord), .y_coord(y_coord),
    .cell_color(cell_color), .game_over(game_over)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {a[4:0], b[4:0], c[4:0], d[4:0]};
  endfunction

  function automatic bit model_can_move(input logic [19:0] xb, input logic [19:0] yb);
    int x, y;
    if (m_over) return 1'b0;
    for (int i = 0; i < 4; i++) begin
      x = int'(xb[19-5*i -: 5]);
      y = int'(yb[19-5*i -: 5]);
      if (x >= COLS || y >= ROWS) return 1'b0;
      if (m[y][x] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Place the piece, then keep only non-full rows, stacked against the bottom.
  task automatic model_lock(input logic [19:0] xb, input logic [19:0] yb, input int col, output int n);
    int x, y, dst;
    bit full;
    int tmp [ROWS][COLS];
    for (int i = 0; i < 4; i++) begin
      x = int'(xb[19-5*i -: 5]);
      y = int'(yb[19-5*i -: 5]);
      if (x < COLS && y < ROWS) m[y][x] = col;
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) tmp[r][c] = 0;
    n = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < COLS; c++) if (m[r][c] == 0) full = 1'b0;
      if (full) n++;
      else begin
        for (int c = 0; c < COLS; c++) tmp[dst][c] = m[r][c];
        dst--;
      end
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = tmp[r][c];
`ifdef PLAYFIELD_TOPOUT_EN
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < COLS; c++) if (m[r][c] != 0) m_over = 1'b1;
`endif
  endtask

  task automatic apply_reset;
    check_valid = 0; cand_xblock = '0; cand_yblock = '0;
    lock_req = 0; lock_xblock = '0; lock_yblock = '0; lock_color = '0;
    play_area = 0; x_coord = '0; y_coord = '0;
    Reset = 1;
    tick;
    tick;
    Reset = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 0;
    m_over = 1'b0;
  endtask

  task automatic run_lock(input logic [19:0] xb, input logic [19:0] yb, input int col, input string name);
    int n, cyc;
    bit early;
    model_lock(xb, yb, col, n);
    lock_xblock = xb; lock_yblock = yb; lock_color = col[2:0]; lock_req = 1;
    tick;
    lock_req = 0;
    checks++;
    if (lock_ack !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s ack: lock_ack/busy got %b/%b want 1/1", name, lock_ack, busy);
    end
    cyc = 0;
    early = 0;
    while (busy === 1'b1 && cyc < 100) begin
      if (clear_done === 1'b1 || (cyc > 0 && lock_ack === 1'b1)) early = 1;
      cyc++;
      tick;
    end
    checks++;
    if (cyc != 21 + n || early) begin
      errors++;
      $display("FAIL %s timing: busy cycles %0d stray pulse %0b want %0d/0", name, cyc, early, 21 + n);
    end
    checks++;
    if (clear_done !== 1'b1 || lines_cleared !== 3'(n) || game_over !== m_over) begin
      errors++;
      $display("FAIL %s result: clear_done/lines/game_over got %b/%0d/%b want 1/%0d/%b",
               name, clear_done, lines_cleared, game_over, n, m_over);
    end
    tick;
    checks++;
    if (clear_done !== 1'b0 || lines_cleared !== 3'(n)) begin
      errors++;
      $display("FAIL %s hold: clear_done/lines got %b/%0d want 0/%0d", name, clear_done, lines_cleared, n);
    end
  endtask

  task automatic test_grid(input string name);
    play_area = 1;
    for (int y = 0; y < ROWS; y++) begin
      for (int x = 0; x < COLS; x++) begin
        x_coord = 5'(x); y_coord = 5'(y);
        tick;
        checks++;
        if (cell_color !== 3'(m[y][x])) begin
          errors++;
          $display("FAIL %s cell(%0d,%0d): got %0d want %0d", name, x, y, cell_color, m[y][x]);
        end
      end
    end
    play_area = 0;
  endtask

  task automatic test_reset;
    apply_reset;
    checks++;
    if (busy !== 0 || check_done !== 0 || can_move !== 0 || lock_ack !== 0) begin
      errors++;
      $display("FAIL reset ctl: busy/check_done/can_move/lock_ack got %b%b%b%b want 0000",
               busy, check_done, can_move, lock_ack);
    end
    checks++;
    if (clear_done !== 0 || lines_cleared !== 0 || cell_color !== 0 || game_over !== 0) begin
      errors++;
      $display("FAIL reset out: clear_done/lines/cell/game_over got %b/%0d/%0d/%b want 0/0/0/0",
               clear_done, lines_cleared, cell_color, game_over);
    end
  endtask

  task automatic test_check_basic;
    logic [19:0] xs, ys;
    xs = pack4(3, 4, 5, 6);
    ys = pack4(4, 4, 4, 4);
    cand_xblock = xs; cand_yblock = ys; check_valid = 1;
    tick;
    check_valid = 0;
    checks++;
    if (check_done !== 1 || can_move !== 1) begin
      errors++;
      $display("FAIL check_empty: check_done/can_move got %b/%b want 1/1", check_done, can_move);
    end
    play_area = 1; x_coord = 3; y_coord = 4;
    tick;
    checks++;
    if (check_done !== 0 || cell_color !== 0) begin
      errors++;
      $display("FAIL check_pulse_read: check_done/cell got %b/%0d want 0/0", check_done, cell_color);
    end
    cand_xblock = pack4(3, 4, 5, 10); check_valid = 1;
    tick;
    checks++;
    if (check_done !== 1 || can_move !== 0) begin
      errors++;
      $display("FAIL check_x10: check_done/can_move got %b/%b want 1/0", check_done, can_move);
    end
    cand_xblock = xs; cand_yblock = pack4(20, 4, 4, 4);
    tick;
    checks++;
    if (check_done !== 1 || can_move !== 0) begin
      errors++;
      $display("FAIL check_y20: check_done/can_move got %b/%b want 1/0", check_done, can_move);
    end
    cand_yblock = ys;
    tick;
    check_valid = 0;
    checks++;
    if (check_done !== 1 || can_move !== 1) begin
      errors++;
      $display("FAIL check_continuous: check_done/can_move got %b/%b want 1/1", check_done, can_move);
    end
    run_lock(xs, ys, 5, "lock_row4");
    check_valid = 1;
    tick;
    check_valid = 0;
    checks++;
    if (check_done !== 1 || can_move !== 0) begin
      errors++;
      $display("FAIL check_blocked: check_done/can_move got %b/%b want 1/0", check_done, can_move);
    end
    play_area = 1; x_coord = 4; y_coord = 4;
    tick;
    checks++;
    if (cell_color !== 3'd5) begin
      errors++;
      $display("FAIL read_44: got %0d want 5", cell_color);
    end
    play_area = 0;
    tick;
    checks++;
    if (cell_color !== 3'd0) begin
      errors++;
      $display("FAIL read_disabled: got %0d want 0", cell_color);
    end
    play_area = 1; x_coord = 10;
    tick;
    checks++;
    if (cell_color !== 3'd0) begin
      errors++;
      $display("FAIL read_x10: got %0d want 0", cell_color);
    end
    x_coord = 4; y_coord = 20;
    tick;
    checks++;
    if (cell_color !== 3'd0) begin
      errors++;
      $display("FAIL read_y20: got %0d want 0", cell_color);
    end
    play_area = 0;
    run_lock(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), 2, "lock_no_clear");
  endtask

  task automatic test_single_clear;
    apply_reset;
    run_lock(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), 1, "pre_a");
    run_lock(pack4(4, 5, 6, 7), pack4(19, 19, 19, 19), 2, "pre_b");
    run_lock(pack4(8, 0, 0, 0), pack4(19, 18, 18, 18), 3, "pre_dup");
    run_lock(pack4(9, 31, 12, 9), pack4(19, 19, 25, 19), 4, "single_clear");
    test_grid("single_grid");
  endtask

  task automatic test_quad_clear;
    apply_reset;
    for (int y = 16; y < 20; y++) begin
      run_lock(pack4(0, 1, 2, 3), pack4(y, y, y, y), 1 + (y % 7), "quad_pre_l");
      run_lock(pack4(4, 5, 6, 7), pack4(y, y, y, y), 2, "quad_pre_r");
    end
    run_lock(pack4(8, 8, 8, 8), pack4(16, 17, 18, 19), 6, "quad_pre_col");
    run_lock(pack4(9, 9, 9, 9), pack4(16, 17, 18, 19), 7, "quad_clear");
    test_grid("quad_grid");
  endtask

  task automatic test_back_to_back;
    logic [19:0] cx, cy;
    int n1, n2, cyc;
    bit stray;
    bit exp;
    apply_reset;
    model_lock(pack4(2, 3, 4, 5), pack4(19, 19, 19, 19), 3, n1);
    model_lock(pack4(5, 5, 5, 5), pack4(15, 16, 17, 18), 4, n2);
    cx = pack4(5, 6, 7, 8); cy = pack4(18, 18, 18, 18);
    exp = model_can_move(cx, cy);
    lock_xblock = pack4(2, 3, 4, 5); lock_yblock = pack4(19, 19, 19, 19); lock_color = 3; lock_req = 1;
    tick;
    checks++;
    if (lock_ack !== 1) begin
      errors++;
      $display("FAIL b2b first_ack: got %b want 1", lock_ack);
    end
    lock_xblock = pack4(5, 5, 5, 5); lock_yblock = pack4(15, 16, 17, 18); lock_color = 4;
    cand_xblock = cx; cand_yblock = cy; check_valid = 1;
    cyc = 0;
    stray = 0;
    do begin
      tick;
      cyc++;
      if (lock_ack === 1 || check_done === 1) stray = 1;
    end while (busy === 1 && cyc < 100);
    checks++;
    if (stray || cyc != 21 + n1) begin
      errors++;
      $display("FAIL b2b holdoff1: stray %0b cycles %0d want 0/%0d", stray, cyc, 21 + n1);
    end
    tick;
    lock_req = 0;
    checks++;
    if (lock_ack !== 1 || check_done !== 0 || busy !== 1) begin
      errors++;
      $display("FAIL b2b priority: lock_ack/check_done/busy got %b/%b/%b want 1/0/1", lock_ack, check_done, busy);
    end
    cyc = 0;
    stray = 0;
    do begin
      tick;
      cyc++;
      if (check_done === 1) stray = 1;
    end while (busy === 1 && cyc < 100);
    checks++;
    if (stray || cyc != 21 + n2 || clear_done !== 1) begin
      errors++;
      $display("FAIL b2b holdoff2: stray %0b cycles %0d clear_done %b want 0/%0d/1", stray, cyc, clear_done, 21 + n2);
    end
    tick;
    check_valid = 0;
    checks++;
    if (check_done !== 1 || can_move !== exp) begin
      errors++;
      $display("FAIL b2b late_check: check_done/can_move got %b/%b want 1/%b", check_done, can_move, exp);
    end
    test_grid("b2b_grid");
  endtask

  task automatic test_reset_mid_scan;
    bit stray;
    apply_reset;
    run_lock(pack4(0, 1, 2, 3), pack4(19, 19, 19, 19), 7, "mid_pre");
    lock_xblock = pack4(4, 5, 6, 7); lock_yblock = pack4(19, 19, 19, 19); lock_color = 1; lock_req = 1;
    tick;
    lock_req = 0;
    repeat (5) tick;
    Reset = 1;
    tick;
    Reset = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m[r][c] = 0;
    m_over = 0;
    checks++;
    if (busy !== 0) begin
      errors++;
      $display("FAIL mid_reset busy: got %b want 0", busy);
    end
    stray = 0;
    repeat (30) begin
      tick;
      if (clear_done === 1 || busy === 1) stray = 1;
    end
    checks++;
    if (stray) begin
      errors++;
      $display("FAIL mid_reset no_done: stray pulse %0b want 0", stray);
    end
    test_grid("mid_reset_grid");
  endtask

  task automatic test_random;
    logic [19:0] xb, yb;
    int x0, y0;
    bit exp;
    apply_reset;
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        x0 = $urandom_range(0, 6);
        y0 = $urandom_range(15, 19);
        xb = pack4(x0, x0 + 1, x0 + 2, x0 + 3);
        yb = pack4(y0, y0, y0, y0);
      end else begin
        xb = pack4($urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11), $urandom_range(0, 11));
        yb = pack4($urandom_range(12, 20), $urandom_range(12, 20), $urandom_range(12, 20), $urandom_range(12, 20));
      end
      run_lock(xb, yb, $urandom_range(1, 7), "rand_lock");
      for (int j = 0; j < 4; j++) begin
        cand_xblock = pack4($urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10), $urandom_range(0, 10));
        cand_yblock = pack4($urandom_range(13, 20), $urandom_range(13, 20), $urandom_range(13, 20), $urandom_range(13, 20));
        exp = model_can_move(cand_xblock, cand_yblock);
        check_valid = 1;
        tick;
        check_valid = 0;
        checks++;
        if (check_done !== 1 || can_move !== exp) begin
          errors++;
          $display("FAIL rand_check: check_done/can_move got %b/%b want 1/%b", check_done, can_move, exp);
        end
      end
    end
    test_grid("rand_grid");
  endtask

  task automatic test_topout;
    bit stray;
    apply_reset;
    run_lock(pack4(0, 31, 31, 31), pack4(1, 31, 31, 31), 6, "topout_lock");
`ifdef PLAYFIELD_TOPOUT_EN
    lock_xblock = pack4(5, 5, 5, 5); lock_yblock = pack4(19, 19, 19, 19); lock_color = 2; lock_req = 1;
    stray = 0;
    repeat (5) begin
      tick;
      if (lock_ack === 1 || busy === 1) stray = 1;
    end
    lock_req = 0;
    checks++;
    if (stray || game_over !== 1) begin
      errors++;
      $display("FAIL topout lock_ignored: stray %0b game_over %b want 0/1", stray, game_over);
    end
`else
    run_lock(pack4(5, 5, 5, 5), pack4(19, 19, 19, 19), 2, "no_topout_lock");
`endif
    cand_xblock = pack4(6, 7, 8, 9); cand_yblock = pack4(10, 10, 10, 10);
    stray = model_can_move(cand_xblock, cand_yblock);
    check_valid = 1;
    tick;
    check_valid = 0;
    checks++;
    if (check_done !== 1 || can_move !== stray) begin
      errors++;
      $display("FAIL topout check: check_done/can_move got %b/%b want 1/%b", check_done, can_move, stray);
    end
  endtask

  initial begin
    test_reset;
    test_check_basic;
    test_single_clear;
    test_quad_clear;
    test_back_to_back;
    test_reset_mid_scan;
    test_random;
    test_topout;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
